shared_memory_reader: RTL and testbench

Read-side sequencer for the per-unit shared memory. It accepts a sweep request (base unit ID, count), drives the memory's combinational read-address port one unit per cycle, and streams captured mv_t vectors to a consumer over a valid/ready interface. Unit addresses wrap modulo NUM_UNITS. A 2-entry output buffer absorbs back-pressure without a combinational ready path to the memory.

---
 rtl/mtx_types.sv | 37 +++
 rtl/mv_beat_fifo2.sv | 47 ++++
 rtl/shared_memory_reader.sv | 102 ++++++++++
 tb/tb_shared_memory_reader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtx_types.sv
// Shared matrix/vector types and shared-memory geometry used by the shared
// memory and its read-side sequencer.
package mtx_types;

  localparam int MV_LEN    = 4;
  localparam int ELEM_W    = 16;
  localparam int NUM_UNITS = 32;
  localparam int UNIT_ID_W = $clog2(NUM_UNITS);
  localparam int CNT_W     = $clog2(NUM_UNITS + 1);
  localparam int BUF_DEPTH = 2;

  typedef logic [MV_LEN-1:0][ELEM_W-1:0] mv_t;
  typedef logic [UNIT_ID_W-1:0]          unit_id_t;
  typedef logic [CNT_W-1:0]              cnt_t;

  typedef struct packed {
    mv_t      data;
    unit_id_t unit_id;
    logic     last;
  } rd_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN
  } rd_state_t;

  // A sweep never needs to touch a unit twice, so longer requests are capped.
  function automatic cnt_t clamp_count(input cnt_t count);
    return (count > cnt_t'(NUM_UNITS)) ? cnt_t'(NUM_UNITS) : count;
  endfunction

  function automatic unit_id_t next_unit(input unit_id_t id);
    return (id == unit_id_t'(NUM_UNITS - 1)) ? '0 : id + unit_id_t'(1);
  endfunction

endpackage

// File: rtl/mv_beat_fifo2.sv
// Two-entry synchronous FIFO of read beats. Push and pop in the same cycle
// are legal even when full, because the head is read before the edge.
module mv_beat_fifo2
  import mtx_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  rd_beat_t wdata,
  output rd_beat_t rdata,
  output logic     full,
  output logic     empty
);

  rd_beat_t   mem [BUF_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  // NOTE: the storage array is deliberately not reset; only pointers and
  // count are. The read port is masked while empty so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/shared_memory_reader.sv
// Read-side sequencer for the per-unit shared memory: walks unit IDs one per
// cycle (wrapping) and streams captured vectors out over valid/ready.
module shared_memory_reader
  import mtx_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_valid,
  output logic     req_ready,
  input  unit_id_t req_base,
  input  cnt_t     req_count,
  output unit_id_t mem_read_unit_id,
  input  mv_t      mem_read_data,
  output logic     out_valid,
  input  logic     out_ready,
  output mv_t      out_data,
  output unit_id_t out_unit_id,
  output logic     out_last,
  output logic     busy,
  output logic     done
);

  rd_state_t state, state_nxt;
  unit_id_t  rd_addr;
  cnt_t      remaining;
  logic      accept, push, pop;
  logic      fifo_full, fifo_empty;
  rd_beat_t  beat_in, head;

  assign req_ready        = (state == ST_IDLE);
  assign busy             = (state != ST_IDLE);
  assign mem_read_unit_id = rd_addr;
  assign out_valid        = !fifo_empty;
  assign pop              = out_valid && out_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = (req_count == '0) ? ST_DRAIN : ST_READ;
        end
      end
      ST_READ: begin
        // A pop frees a slot in the same cycle, so a full buffer still streams.
        push = !fifo_full || pop;
        if (push && remaining == cnt_t'(1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr   <= '0;
      remaining <= '0;
    end else if (accept) begin
      rd_addr   <= req_base;
      remaining <= clamp_count(req_count);
    end else if (push) begin
      rd_addr   <= next_unit(rd_addr);
      remaining <= remaining - cnt_t'(1);
    end
  end

  assign beat_in = '{data: mem_read_data, unit_id: rd_addr, last: (remaining == cnt_t'(1))};

  mv_beat_fifo2 u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (beat_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_data    = head.data;
  assign out_unit_id = head.unit_id;
  assign out_last    = head.last;

endmodule

// File: tb/tb_shared_memory_reader.sv
// Self-checking bench for shared_memory_reader: behavioural shared memory,
// scoreboard of expected beats, table of sweeps plus reset/coherency sequences.
module tb_shared_memory_reader;
  import mtx_types::*;

  logic     clk = 1'b0;
  logic     rst;
  logic     req_valid;
  logic     req_ready;
  unit_id_t req_base;
  cnt_t     req_count;
  unit_id_t mem_read_unit_id;
  mv_t      mem_read_data;
  logic     out_valid;
  logic     out_ready = 1'b0;
  mv_t      out_data;
  unit_id_t out_unit_id;
  logic     out_last;
  logic     busy;
  logic     done;

  shared_memory_reader dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_base         (req_base),
    .req_count        (req_count),
    .mem_read_unit_id (mem_read_unit_id),
    .mem_read_data    (mem_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_unit_id      (out_unit_id),
    .out_last         (out_last),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural shared memory: pattern by default, overridden by writes.
  logic [NUM_UNITS-1:0] ovr_valid;
  mv_t                  ovr_data [NUM_UNITS];
  logic                 wr_en;
  unit_id_t             wr_addr;
  mv_t                  wr_data;

  function automatic mv_t pattern(input int i);
    mv_t v;
    for (int k = 0; k < MV_LEN; k++) v[k] = 16'h5000 + 16'(i * 16) + 16'(k);
    return v;
  endfunction

  function automatic mv_t mem_value(input int i);
    return ovr_valid[i] ? ovr_data[i] : pattern(i);
  endfunction

  always @(posedge clk) begin
    if (rst) ovr_valid <= '0;
    else if (wr_en) begin
      ovr_valid[wr_addr] <= 1'b1;
      ovr_data[wr_addr]  <= wr_data;
    end
  end

  always_comb begin
    mem_read_data = ovr_valid[mem_read_unit_id] ? ovr_data[mem_read_unit_id]
                                                : pattern(int'(mem_read_unit_id));
  end

  // out_ready driver: fixed level or the repeating 1,0,0,1 stall pattern.
  logic rdy_mode  = 1'b0;
  logic rdy_fixed = 1'b1;
  int   ph = 0;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode) begin
        out_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        out_ready = rdy_fixed;
      end
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  rd_beat_t exp_q[$];
  int       cyc = 0, beats = 0, done_cnt = 0, done_cyc = 0, last_pop_cyc = 0, acc_cyc = 0;
  logic     prev_stall = 1'b0;
  rd_beat_t prev_beat;
  mv_t      seen_u10;

  always @(negedge clk) begin
    rd_beat_t act, e;
    cyc++;
    act = '{data: out_data, unit_id: out_unit_id, last: out_last};
    if (!rst) begin
      if (prev_stall) begin
        check("hold_valid", 128'(out_valid), 128'(1));
        check("hold_beat", 128'(act), 128'(prev_beat));
      end
      check("occupancy", 128'(dut.u_fifo.count <= 2'd2), 128'(1));
      if (out_valid) check("busy_during_beat", 128'(busy), 128'(1));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_without_beat", 128'(out_valid), 128'(0));
      end
      if (out_valid && out_ready) begin
        beats++;
        last_pop_cyc = cyc;
        if (act.unit_id == unit_id_t'(10)) seen_u10 = act.data;
        if (exp_q.size() == 0) check("unexpected_beat", 128'(act), 128'(0));
        else begin
          e = exp_q.pop_front();
          check("beat", 128'(act), 128'(e));
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_beat  = act;
  end

  // Called right after a rising edge (+#1); returns right after the accepting edge.
  task automatic send_req(input int base, input int count);
    int n;
    n = (count > NUM_UNITS) ? NUM_UNITS : count;
    for (int i = 0; i < n; i++)
      exp_q.push_back('{data: mem_value((base + i) % NUM_UNITS),
                        unit_id: unit_id_t'((base + i) % NUM_UNITS),
                        last: (i == n - 1)});
    check("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_base  = unit_id_t'(base);
    req_count = cnt_t'(count);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc_cyc   = cyc;
    check("busy_after_accept", 128'(busy), 128'(1));
    check("no_beat_at_accept", 128'(out_valid), 128'(0));
  endtask

  task automatic wait_done(input int exp_beats, input int beats0, input int done0, input bit zero);
    int t;
    t = 0;
    while (done_cnt == done0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("done_seen", 128'(done_cnt > done0), 128'(1));
    if (zero) check("done_timing_empty", 128'(done_cyc), 128'(acc_cyc + 1));
    else      check("done_after_last_pop", 128'(done_cyc), 128'(last_pop_cyc + 1));
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 128'(done_cnt), 128'(done0 + 1));
    check("beat_count", 128'(beats - beats0), 128'(exp_beats));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    check("idle_ready", 128'(req_ready), 128'(1));
    check("idle_busy", 128'(busy), 128'(0));
  endtask

  typedef struct {
    int base;
    int count;
    bit toggle;
    int exp_beats;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0, d0, t;
    mv_t x_val;

    vecs[0] = '{base: 3,  count: 1,  toggle: 1'b0, exp_beats: 1};
    vecs[1] = '{base: 30, count: 4,  toggle: 1'b0, exp_beats: 4};
    vecs[2] = '{base: 0,  count: 32, toggle: 1'b1, exp_beats: 32};
    vecs[3] = '{base: 0,  count: 0,  toggle: 1'b0, exp_beats: 0};
    vecs[4] = '{base: 5,  count: 40, toggle: 1'b0, exp_beats: 32};
    vecs[5] = '{base: 17, count: 7,  toggle: 1'b1, exp_beats: 7};

    rst = 1'b1; req_valid = 1'b0; req_base = '0; req_count = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_out_unit_id", 128'(out_unit_id), 128'(0));
    check("rst_out_last", 128'(out_last), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_mem_addr", 128'(mem_read_unit_id), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rdy_mode  = vecs[i].toggle;
      rdy_fixed = 1'b1;
      @(posedge clk);
      #1;
      b0 = beats;
      d0 = done_cnt;
      send_req(vecs[i].base, vecs[i].count);
      if (vecs[i].count != 0) begin
        @(posedge clk);
        #1;
        check("first_beat_latency", 128'(out_valid), 128'(1));
      end
      wait_done(vecs[i].exp_beats, b0, d0, vecs[i].count == 0);
    end

    // Reset after the fifth beat of a 16-unit sweep: no done, nothing left over.
    rdy_mode = 1'b0; rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    b0 = beats;
    d0 = done_cnt;
    send_req(0, 16);
    t = 0;
    while (beats - b0 < 5 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    b0 = beats;
    send_req(8, 2);
    wait_done(2, b0, done_cnt, 1'b0);

    // Write to unit 10 at the edge that captures it: old value, then new on a repeat.
    x_val = 64'hDEAD_BEEF_0BAD_F00D;
    b0 = beats;
    d0 = done_cnt;
    send_req(0, 16);
    t = 0;
    while (!(busy && mem_read_unit_id == unit_id_t'(10)) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("reach_unit10", 128'(mem_read_unit_id), 128'(10));
    wr_en = 1'b1; wr_addr = unit_id_t'(10); wr_data = x_val;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    wait_done(16, b0, d0, 1'b0);
    check("unit10_old_value", 128'(seen_u10), 128'(pattern(10)));
    b0 = beats;
    d0 = done_cnt;
    send_req(0, 16);
    wait_done(16, b0, d0, 1'b0);
    check("unit10_new_value", 128'(seen_u10), 128'(x_val));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
